// File: rtl/axi_burst_master_test_pkg.sv
// Shared types and AXI constants for the burst self-test master.
// Imported by the master top and its pattern generator.
package axi_burst_master_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    localparam int BEAT_W    = 9;
    localparam int ERR_CNT_W = 9;

endpackage

// File: rtl/axi_pattern_gen.sv
// Expected-word source: seed plus a beat counter.
// Shared by the write and read-compare phases.
module axi_pattern_gen
    import axi_burst_master_test_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              advance,
    input  logic [DATA_W-1:0] seed,
    output logic [BEAT_W-1:0] beat,
    output logic [DATA_W-1:0] data
);

    // Beat counter: cleared at phase start, bumped per handshake.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            beat <= '0;
        end else if (advance) begin
            beat <= beat + 1'b1;
        end
    end

    assign data = seed + DATA_W'(beat);

endmodule

// File: rtl/axi_burst_master_test.sv
// AXI4 burst master: writes a counting INCR burst, reads it back
// and compares every beat, reporting done, error and mismatch count.
module axi_burst_master_test
    import axi_burst_master_test_pkg::*;
#(
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 8,
    parameter int C_M_AXI_BURST_LEN  = 16
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic                            I_START,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   I_BASE_ADDR,
    input  logic [31:0]                     I_SEED,
    output logic                            O_BUSY,
    output logic                            O_DONE,
    output logic                            O_ERROR,
    output logic [ERR_CNT_W-1:0]            O_ERR_CNT,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWLOCK,
    output logic [3:0]                      M_AXI_AWCACHE,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic [3:0]                      M_AXI_AWQOS,
    output logic [3:0]                      M_AXI_AWREGION,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    output logic                            M_AXI_ARLOCK,
    output logic [3:0]                      M_AXI_ARCACHE,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic [3:0]                      M_AXI_ARQOS,
    output logic [3:0]                      M_AXI_ARREGION,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam logic [BEAT_W-1:0] LAST_BEAT =
        BEAT_W'(C_M_AXI_BURST_LEN - 1);

    state_t state;
    state_t state_nxt;

    logic [C_M_AXI_ADDR_WIDTH-1:0] base_q;
    logic [31:0]                   seed_q;
    logic                          error_q;
    logic [ERR_CNT_W-1:0]          err_cnt_q;
    logic [BEAT_W-1:0]             beat;
    logic [C_M_AXI_DATA_WIDTH-1:0] pat;

    logic start_ok;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic last_beat;
    logic r_end;
    logic unused_ids;

    assign start_ok  = (state == ST_IDLE) && I_START;
    assign aw_hs     = (state == ST_AW) && M_AXI_AWREADY;
    assign w_hs      = (state == ST_W) && M_AXI_WREADY;
    assign b_hs      = (state == ST_B) && M_AXI_BVALID;
    assign ar_hs     = (state == ST_AR) && M_AXI_ARREADY;
    assign r_hs      = (state == ST_R) && M_AXI_RVALID;
    assign last_beat = (beat == LAST_BEAT);
    assign r_end     = r_hs && (M_AXI_RLAST || last_beat);

    assign unused_ids = ^{M_AXI_BID, M_AXI_RID};

    axi_pattern_gen #(
        .DATA_W (C_M_AXI_DATA_WIDTH)
    ) u_pat (
        .clk     (M_AXI_ACLK),
        .rst     (M_AXI_ARESET),
        .restart (start_ok || ar_hs),
        .advance (w_hs || r_hs),
        .seed    (C_M_AXI_DATA_WIDTH'(seed_q)),
        .beat    (beat),
        .data    (pat)
    );

    // State register.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Phase sequencing driven by channel handshakes.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (I_START) state_nxt = ST_AW;
            ST_AW:   if (M_AXI_AWREADY) state_nxt = ST_W;
            ST_W:    if (M_AXI_WREADY && last_beat) state_nxt = ST_B;
            ST_B:    if (M_AXI_BVALID) state_nxt = ST_AR;
            ST_AR:   if (M_AXI_ARREADY) state_nxt = ST_R;
            ST_R:    if (r_end) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Test parameters and result flags.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            base_q    <= '0;
            seed_q    <= '0;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            if (start_ok) begin
                base_q    <= I_BASE_ADDR;
                seed_q    <= I_SEED;
                error_q   <= 1'b0;
                err_cnt_q <= '0;
            end
            if (b_hs && (M_AXI_BRESP != AXI_RESP_OKAY)) begin
                error_q <= 1'b1;
            end
            if (r_hs) begin
                if (M_AXI_RDATA != pat) begin
                    error_q <= 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_q <= err_cnt_q + 1'b1;
                    end
                end
                if (M_AXI_RRESP != AXI_RESP_OKAY) begin
                    error_q <= 1'b1;
                end
                if (M_AXI_RLAST != last_beat) begin
                    error_q <= 1'b1;
                end
            end
        end
    end

    assign O_BUSY    = (state != ST_IDLE);
    assign O_DONE    = (state == ST_DONE);
    assign O_ERROR   = error_q;
    assign O_ERR_CNT = err_cnt_q;

    assign M_AXI_AWID     = '0;
    assign M_AXI_AWADDR   = base_q;
    assign M_AXI_AWLEN    = 8'(C_M_AXI_BURST_LEN - 1);
    assign M_AXI_AWSIZE   = AXI_SIZE_4B;
    assign M_AXI_AWBURST  = AXI_BURST_INCR;
    assign M_AXI_AWLOCK   = 1'b0;
    assign M_AXI_AWCACHE  = '0;
    assign M_AXI_AWPROT   = '0;
    assign M_AXI_AWQOS    = '0;
    assign M_AXI_AWREGION = '0;
    assign M_AXI_AWVALID  = (state == ST_AW);

    assign M_AXI_WDATA  = pat;
    assign M_AXI_WSTRB  = '1;
    assign M_AXI_WLAST  = (state == ST_W) && last_beat;
    assign M_AXI_WVALID = (state == ST_W);

    assign M_AXI_BREADY = (state == ST_B);

    assign M_AXI_ARID     = '0;
    assign M_AXI_ARADDR   = base_q;
    assign M_AXI_ARLEN    = 8'(C_M_AXI_BURST_LEN - 1);
    assign M_AXI_ARSIZE   = AXI_SIZE_4B;
    assign M_AXI_ARBURST  = AXI_BURST_INCR;
    assign M_AXI_ARLOCK   = 1'b0;
    assign M_AXI_ARCACHE  = '0;
    assign M_AXI_ARPROT   = '0;
    assign M_AXI_ARQOS    = '0;
    assign M_AXI_ARREGION = '0;
    assign M_AXI_ARVALID  = (state == ST_AR);

    assign M_AXI_RREADY = (state == ST_R);

endmodule

// File: tb/tb_axi_burst_master_test.sv
// Directed bench for the burst master against a behavioural slave,
// plus a second single-beat instance.
module tb_axi_burst_master_test;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- main instance (BURST_LEN 16) ----------------
    logic        start = 1'b0;
    logic [7:0]  base = 8'h00;
    logic [31:0] seed = 32'h0;
    logic        busy, done, error;
    logic [8:0]  err_cnt;
    logic [0:0]  awid, arid;
    logic [7:0]  awaddr, awlen, araddr, arlen;
    logic [2:0]  awsize, awprot, arsize, arprot;
    logic [1:0]  awburst, arburst;
    logic        awlock, arlock;
    logic [3:0]  awcache, awqos, awregion, arcache, arqos, arregion;
    logic        awvalid, wvalid, wlast, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready = 1'b0;
    logic        wready = 1'b0;
    logic        arready = 1'b0;
    logic        bvalid = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rlast = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [0:0]  bid = 1'b0;
    logic [0:0]  rid = 1'b0;
    logic [1:0]  rresp = 2'b00;

    axi_burst_master_test #(
        .C_M_AXI_BURST_LEN (16)
    ) dut (
        .M_AXI_ACLK (clk), .M_AXI_ARESET (rst),
        .I_START (start), .I_BASE_ADDR (base), .I_SEED (seed),
        .O_BUSY (busy), .O_DONE (done), .O_ERROR (error),
        .O_ERR_CNT (err_cnt),
        .M_AXI_AWID (awid), .M_AXI_AWADDR (awaddr),
        .M_AXI_AWLEN (awlen), .M_AXI_AWSIZE (awsize),
        .M_AXI_AWBURST (awburst), .M_AXI_AWLOCK (awlock),
        .M_AXI_AWCACHE (awcache), .M_AXI_AWPROT (awprot),
        .M_AXI_AWQOS (awqos), .M_AXI_AWREGION (awregion),
        .M_AXI_AWVALID (awvalid), .M_AXI_AWREADY (awready),
        .M_AXI_WDATA (wdata), .M_AXI_WSTRB (wstrb),
        .M_AXI_WLAST (wlast), .M_AXI_WVALID (wvalid),
        .M_AXI_WREADY (wready),
        .M_AXI_BID (bid), .M_AXI_BRESP (bresp),
        .M_AXI_BVALID (bvalid), .M_AXI_BREADY (bready),
        .M_AXI_ARID (arid), .M_AXI_ARADDR (araddr),
        .M_AXI_ARLEN (arlen), .M_AXI_ARSIZE (arsize),
        .M_AXI_ARBURST (arburst), .M_AXI_ARLOCK (arlock),
        .M_AXI_ARCACHE (arcache), .M_AXI_ARPROT (arprot),
        .M_AXI_ARQOS (arqos), .M_AXI_ARREGION (arregion),
        .M_AXI_ARVALID (arvalid), .M_AXI_ARREADY (arready),
        .M_AXI_RID (rid), .M_AXI_RDATA (rdata),
        .M_AXI_RRESP (rresp), .M_AXI_RLAST (rlast),
        .M_AXI_RVALID (rvalid), .M_AXI_RREADY (rready)
    );

    // ---------------- slave model knobs ----------------
    bit          bp = 1'b0;
    int          corrupt = -1;
    logic [1:0]  bresp_cfg = 2'b00;

    logic [31:0] mem [0:63];
    logic [5:0]  w_ptr = '0;
    int          w_cnt = 0;
    int          w_last_idx = -1;
    int          ar_cnt = 0;
    logic [5:0]  r_base = '0;
    int          r_idx = 0;
    int          r_left = 0;

    always @(posedge clk) begin
        awready <= bp ? 1'($urandom_range(0, 1)) : 1'b1;
        wready  <= bp ? 1'($urandom_range(0, 1)) : 1'b1;
        arready <= bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(posedge clk) begin
        if (rst) begin
            w_cnt  <= 0;
            bvalid <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                w_ptr      <= awaddr[7:2];
                w_cnt      <= 0;
                w_last_idx <= -1;
            end
            if (wvalid && wready) begin
                mem[w_ptr + w_cnt[5:0]] <= wdata;
                if (wlast) w_last_idx <= w_cnt;
                w_cnt <= w_cnt + 1;
            end
            if (wvalid && wready && wlast) begin
                bvalid <= 1'b1;
                bresp  <= bresp_cfg;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            r_left <= 0;
        end else if (arvalid && arready) begin
            r_base <= araddr[7:2];
            r_idx  <= 0;
            r_left <= 16;
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            ar_cnt <= ar_cnt + 1;
        end else if (!rvalid || rready) begin
            if (r_left != 0 && (!bp || $urandom_range(0, 2) != 0)) begin
                rvalid <= 1'b1;
                rdata  <= mem[r_base + r_idx[5:0]] ^
                          ((r_idx == corrupt) ? 32'h1 : 32'h0);
                rlast  <= (r_left == 1);
                r_idx  <= r_idx + 1;
                r_left <= r_left - 1;
            end else begin
                rvalid <= 1'b0;
                rlast  <= 1'b0;
            end
        end
    end

    // Payload hold monitor: a stalled VALID must keep its payload.
    bit          aw_pend = 0, w_pend = 0, ar_pend = 0;
    logic [7:0]  aw_q, ar_q;
    logic [31:0] w_q;
    logic        wl_q;
    int          hold_seen = 0;
    int          hold_errs = 0;

    always @(negedge clk) begin
        if (rst) begin
            aw_pend = 0;
            w_pend  = 0;
            ar_pend = 0;
        end else begin
            if (aw_pend) begin
                hold_seen++;
                if (!awvalid || awaddr !== aw_q) begin
                    hold_errs++;
                    $display("FAIL aw_hold: got v=%0b a=%0h need a=%0h",
                             awvalid, awaddr, aw_q);
                end
            end
            if (w_pend) begin
                hold_seen++;
                if (!wvalid || wdata !== w_q || wlast !== wl_q) begin
                    hold_errs++;
                    $display("FAIL w_hold: got v=%0b d=%0h need d=%0h",
                             wvalid, wdata, w_q);
                end
            end
            if (ar_pend) begin
                hold_seen++;
                if (!arvalid || araddr !== ar_q) begin
                    hold_errs++;
                    $display("FAIL ar_hold: got v=%0b a=%0h need a=%0h",
                             arvalid, araddr, ar_q);
                end
            end
            aw_pend = awvalid && !awready;
            w_pend  = wvalid && !wready;
            ar_pend = arvalid && !arready;
            aw_q    = awaddr;
            w_q     = wdata;
            wl_q    = wlast;
            ar_q    = araddr;
        end
    end

    // ---------------- single-beat instance ----------------
    logic        d1_start = 1'b0;
    logic        d1_busy, d1_done, d1_error;
    logic [8:0]  d1_err_cnt;
    logic [0:0]  d1_awid, d1_arid;
    logic [7:0]  d1_awaddr, d1_awlen, d1_araddr, d1_arlen;
    logic [2:0]  d1_awsize, d1_awprot, d1_arsize, d1_arprot;
    logic [1:0]  d1_awburst, d1_arburst;
    logic        d1_awlock, d1_arlock;
    logic [3:0]  d1_awcache, d1_awqos, d1_awregion;
    logic [3:0]  d1_arcache, d1_arqos, d1_arregion;
    logic        d1_awvalid, d1_wvalid, d1_wlast, d1_bready;
    logic        d1_arvalid, d1_rready;
    logic [31:0] d1_wdata;
    logic [3:0]  d1_wstrb;
    logic        one = 1'b1;
    logic [1:0]  zero2 = 2'b00;
    logic [0:0]  zero1 = 1'b0;
    logic [31:0] w1_word = 32'h0;
    logic        w1_last = 1'b0;
    int          w1_cnt = 0;

    axi_burst_master_test #(
        .C_M_AXI_BURST_LEN (1)
    ) dut1 (
        .M_AXI_ACLK (clk), .M_AXI_ARESET (rst),
        .I_START (d1_start), .I_BASE_ADDR (8'h10),
        .I_SEED (32'hABCD_0001),
        .O_BUSY (d1_busy), .O_DONE (d1_done), .O_ERROR (d1_error),
        .O_ERR_CNT (d1_err_cnt),
        .M_AXI_AWID (d1_awid), .M_AXI_AWADDR (d1_awaddr),
        .M_AXI_AWLEN (d1_awlen), .M_AXI_AWSIZE (d1_awsize),
        .M_AXI_AWBURST (d1_awburst), .M_AXI_AWLOCK (d1_awlock),
        .M_AXI_AWCACHE (d1_awcache), .M_AXI_AWPROT (d1_awprot),
        .M_AXI_AWQOS (d1_awqos), .M_AXI_AWREGION (d1_awregion),
        .M_AXI_AWVALID (d1_awvalid), .M_AXI_AWREADY (one),
        .M_AXI_WDATA (d1_wdata), .M_AXI_WSTRB (d1_wstrb),
        .M_AXI_WLAST (d1_wlast), .M_AXI_WVALID (d1_wvalid),
        .M_AXI_WREADY (one),
        .M_AXI_BID (zero1), .M_AXI_BRESP (zero2),
        .M_AXI_BVALID (one), .M_AXI_BREADY (d1_bready),
        .M_AXI_ARID (d1_arid), .M_AXI_ARADDR (d1_araddr),
        .M_AXI_ARLEN (d1_arlen), .M_AXI_ARSIZE (d1_arsize),
        .M_AXI_ARBURST (d1_arburst), .M_AXI_ARLOCK (d1_arlock),
        .M_AXI_ARCACHE (d1_arcache), .M_AXI_ARPROT (d1_arprot),
        .M_AXI_ARQOS (d1_arqos), .M_AXI_ARREGION (d1_arregion),
        .M_AXI_ARVALID (d1_arvalid), .M_AXI_ARREADY (one),
        .M_AXI_RID (zero1), .M_AXI_RDATA (w1_word),
        .M_AXI_RRESP (zero2), .M_AXI_RLAST (one),
        .M_AXI_RVALID (one), .M_AXI_RREADY (d1_rready)
    );

    always @(posedge clk) begin
        if (rst) begin
            w1_cnt <= 0;
        end else if (d1_wvalid) begin
            w1_word <= d1_wdata;
            w1_last <= d1_wlast;
            w1_cnt  <= w1_cnt + 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic run_burst(input logic [7:0] b, input logic [31:0] s,
                             output bit got, output int cyc,
                             output logic aw_first, output logic busy_first);
        @(posedge clk); #1;
        start = 1'b1;
        base  = b;
        seed  = s;
        @(posedge clk); #1;
        start = 1'b0;
        got = 0;
        cyc = -1;
        aw_first = 1'b0;
        busy_first = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 0) begin
                aw_first = awvalid;
                busy_first = busy;
            end
            if (done) begin
                got = 1;
                cyc = i;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, wlast} !== 6'b0) begin
            errors++;
            $display("FAIL reset_valids: got %b need 000000",
                     {awvalid, wvalid, bready, arvalid, rready, wlast});
        end
        checks++;
        if ({busy, done, error} !== 3'b0 || err_cnt !== 9'd0) begin
            errors++;
            $display("FAIL reset_status: got b%0b d%0b e%0b c%0d need 0",
                     busy, done, error, err_cnt);
        end
        checks++;
        if (awaddr !== 8'h0 || araddr !== 8'h0 || wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_payload: got %0h %0h %0h need 0",
                     awaddr, araddr, wdata);
        end
        checks++;
        if ({awlock, awcache, awprot, awqos, awregion} !== 16'h0) begin
            errors++;
            $display("FAIL tieoffs: got %0h need 0",
                     {awlock, awcache, awprot, awqos, awregion});
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit got;
        int cyc;
        logic awf, bsf;
        run_burst(8'h00, 32'h1000_0000, got, cyc, awf, bsf);
        checks++;
        if (!awf || !bsf) begin
            errors++;
            $display("FAIL aw_rise: got aw=%0b busy=%0b need 1 1", awf, bsf);
        end
        checks++;
        if (!got || cyc !== 36) begin
            errors++;
            $display("FAIL basic_done: got done=%0b cyc=%0d need 1 36",
                     got, cyc);
        end
        checks++;
        if (error !== 1'b0 || err_cnt !== 9'd0) begin
            errors++;
            $display("FAIL basic_err: got %0b/%0d need 0/0", error, err_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mem[i] !== 32'h1000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL wdata[%0d]: got %0h need %0h",
                         i, mem[i], 32'h1000_0000 + 32'(i));
            end
        end
        checks++;
        if (w_last_idx !== 15 || w_cnt !== 16) begin
            errors++;
            $display("FAIL wlast_pos: got idx=%0d beats=%0d need 15 16",
                     w_last_idx, w_cnt);
        end
        checks++;
        if (awlen !== 8'd15 || awsize !== 3'b010 || awburst !== 2'b01) begin
            errors++;
            $display("FAIL aw_fields: got %0h %0h %0h need f 2 1",
                     awlen, awsize, awburst);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got %0b need 0", done);
        end
    endtask

    task automatic test_corrupt();
        bit got;
        int cyc;
        logic awf, bsf;
        corrupt = 5;
        run_burst(8'h00, 32'h1000_0000, got, cyc, awf, bsf);
        corrupt = -1;
        checks++;
        if (!got || error !== 1'b1 || err_cnt !== 9'd1) begin
            errors++;
            $display("FAIL corrupt: got d=%0b e=%0b c=%0d need 1 1 1",
                     got, error, err_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit got;
        int cyc;
        logic awf, bsf;
        bp = 1'b1;
        run_burst(8'h40, 32'h1000_0000, got, cyc, awf, bsf);
        bp = 1'b0;
        checks++;
        if (!got || error !== 1'b0 || err_cnt !== 9'd0) begin
            errors++;
            $display("FAIL bp_result: got d=%0b e=%0b c=%0d need 1 0 0",
                     got, error, err_cnt);
        end
        checks++;
        if (mem[16] !== 32'h1000_0000 || mem[31] !== 32'h1000_000F) begin
            errors++;
            $display("FAIL bp_data: got %0h %0h need 10000000 1000000f",
                     mem[16], mem[31]);
        end
        checks++;
        if (hold_errs !== 0 || hold_seen == 0) begin
            errors++;
            $display("FAIL bp_hold: got errs=%0d stalls=%0d need 0 >0",
                     hold_errs, hold_seen);
        end
    endtask

    task automatic test_bresp();
        bit got;
        int cyc;
        logic awf, bsf;
        int ar_before;
        ar_before = ar_cnt;
        bresp_cfg = 2'b10;
        run_burst(8'h00, 32'h3000_0000, got, cyc, awf, bsf);
        bresp_cfg = 2'b00;
        checks++;
        if (!got || error !== 1'b1 || err_cnt !== 9'd0) begin
            errors++;
            $display("FAIL bresp: got d=%0b e=%0b c=%0d need 1 1 0",
                     got, error, err_cnt);
        end
        checks++;
        if (ar_cnt !== ar_before + 1) begin
            errors++;
            $display("FAIL bresp_read: got %0d need %0d",
                     ar_cnt, ar_before + 1);
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        bit saw;
        int cyc;
        logic awf, bsf;
        @(posedge clk); #1;
        start = 1'b1;
        base  = 8'h00;
        seed  = 32'h2000_0000;
        @(posedge clk); #1;
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (w_cnt == 7 && wvalid) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL reach_beat7: got 0 need 1");
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, busy, done}
            !== 7'b0) begin
            errors++;
            $display("FAIL mid_reset: got %b need 0000000",
                     {awvalid, wvalid, bready, arvalid, rready, busy, done});
        end
        rst = 1'b0;
        saw = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) saw = 1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL no_done: got 1 need 0");
        end
        run_burst(8'h00, 32'h2000_0000, got, cyc, awf, bsf);
        checks++;
        if (!got || error !== 1'b0 || err_cnt !== 9'd0) begin
            errors++;
            $display("FAIL after_reset: got d=%0b e=%0b c=%0d need 1 0 0",
                     got, error, err_cnt);
        end
    endtask

    task automatic test_wrap();
        bit got;
        int cyc;
        logic awf, bsf;
        run_burst(8'h80, 32'hFFFF_FFF8, got, cyc, awf, bsf);
        checks++;
        if (!got || error !== 1'b0 || err_cnt !== 9'd0) begin
            errors++;
            $display("FAIL wrap_result: got d=%0b e=%0b c=%0d need 1 0 0",
                     got, error, err_cnt);
        end
        checks++;
        if (mem[39] !== 32'hFFFF_FFFF || mem[40] !== 32'h0 ||
            mem[47] !== 32'h0000_0007) begin
            errors++;
            $display("FAIL wrap_data: got %0h %0h %0h need ffffffff 0 7",
                     mem[39], mem[40], mem[47]);
        end
    endtask

    task automatic test_len1();
        bit got;
        @(posedge clk); #1;
        d1_start = 1'b1;
        @(posedge clk); #1;
        d1_start = 1'b0;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (d1_done) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got || d1_error !== 1'b0 || d1_err_cnt !== 9'd0) begin
            errors++;
            $display("FAIL len1_done: got d=%0b e=%0b c=%0d need 1 0 0",
                     got, d1_error, d1_err_cnt);
        end
        checks++;
        if (w1_cnt !== 1 || w1_last !== 1'b1 ||
            w1_word !== 32'hABCD_0001) begin
            errors++;
            $display("FAIL len1_w: got n=%0d last=%0b d=%0h need 1 1 abcd0001",
                     w1_cnt, w1_last, w1_word);
        end
        checks++;
        if (d1_awlen !== 8'd0) begin
            errors++;
            $display("FAIL len1_awlen: got %0d need 0", d1_awlen);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corrupt();
        test_backpressure();
        test_bresp();
        test_reset_mid();
        test_wrap();
        test_len1();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
